// File: rtl/ram_init_ctrl_if.sv
// Loader-side bus bundle for ram_init_ctrl: start pulse, flash read port,
// RAM select/write controls and status outputs.
interface ram_init_ctrl_if;
  logic        start;
  logic [21:0] flash_addr;
  logic        flash_rd_req;
  logic        flash_ack;
  logic [15:0] flash_data;
  logic        initializing;
  logic [15:0] init_addr;
  logic [15:0] init_data;
  logic        ram_we_n;
  logic        busy;
  logic        done;
  logic [15:0] checksum;

  modport master (
    input  start, flash_ack, flash_data,
    output flash_addr, flash_rd_req, initializing, init_addr, init_data,
           ram_we_n, busy, done, checksum
  );

  modport slave (
    output start, flash_ack, flash_data,
    input  flash_addr, flash_rd_req, initializing, init_addr, init_data,
           ram_we_n, busy, done, checksum
  );
endinterface

// File: rtl/ram_init_ctrl.sv
// Boot loader copying WORDS flash words into RAM before the CPU runs.
// Optional running checksum of copied words: define RAM_INIT_CHECKSUM_EN.
module ram_init_ctrl #(
  parameter logic [15:0] WORDS      = 16'h0200,
  parameter logic [21:0] FLASH_BASE = 22'h000000,
  parameter logic [15:0] RAM_BASE   = 16'h0000,
  parameter int          WR_CYCLES  = 2
) (
  input  logic            clk,
  input  logic            rst,
  ram_init_ctrl_if.master bus
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] READ   = 3'd1;
  localparam logic [2:0] SETUP  = 3'd2;
  localparam logic [2:0] WRITE  = 3'd3;
  localparam logic [2:0] HOLD   = 3'd4;
  localparam logic [2:0] FINISH = 3'd5;

  localparam int             WCW     = (WR_CYCLES > 1) ? $clog2(WR_CYCLES) : 1;
  localparam logic [WCW-1:0] WR_LAST = WCW'(WR_CYCLES - 1);

  logic [2:0]     state;
  logic [15:0]    count;
  logic [15:0]    count_nxt;
  logic [WCW-1:0] wr_cnt;
  logic [21:0]    flash_addr_q;
  logic           rd_req_q;
  logic           init_q;
  logic [15:0]    addr_q;
  logic [15:0]    data_q;
  logic           we_n_q;
  logic           busy_q;
  logic           done_q;

  assign count_nxt = count + 16'd1;

  // Outputs are registered and only change on state transitions, so the RAM
  // sees addr/data settle in SETUP before the write strobe drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      count        <= '0;
      wr_cnt       <= '0;
      flash_addr_q <= FLASH_BASE;
      rd_req_q     <= 1'b0;
      init_q       <= 1'b0;
      addr_q       <= RAM_BASE;
      data_q       <= '0;
      we_n_q       <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (WORDS == 16'd0) begin
              state  <= FINISH;
              done_q <= 1'b1;
            end else begin
              state        <= READ;
              count        <= '0;
              flash_addr_q <= FLASH_BASE;
              rd_req_q     <= 1'b1;
              init_q       <= 1'b1;
              busy_q       <= 1'b1;
            end
          end
        end
        READ: begin
          if (bus.flash_ack) begin
            data_q   <= bus.flash_data;
            addr_q   <= RAM_BASE + count;
            rd_req_q <= 1'b0;
            state    <= SETUP;
          end
        end
        SETUP: begin
          we_n_q <= 1'b0;
          wr_cnt <= WR_LAST;
          state  <= WRITE;
        end
        WRITE: begin
          if (wr_cnt == '0) begin
            we_n_q <= 1'b1;
            state  <= HOLD;
          end else begin
            wr_cnt <= wr_cnt - WCW'(1);
          end
        end
        HOLD: begin
          if (count == WORDS - 16'd1) begin
            init_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= FINISH;
          end else begin
            count        <= count_nxt;
            flash_addr_q <= FLASH_BASE + {6'd0, count_nxt};
            rd_req_q     <= 1'b1;
            state        <= READ;
          end
        end
        FINISH: begin
          state <= FINISH;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef RAM_INIT_CHECKSUM_EN
  logic [15:0] csum_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      csum_q <= '0;
    end else if (state == READ && bus.flash_ack) begin
      csum_q <= csum_q + bus.flash_data;
    end
  end

  assign bus.checksum = csum_q;
`else
  assign bus.checksum = 16'h0000;
`endif

  assign bus.flash_addr   = flash_addr_q;
  assign bus.flash_rd_req = rd_req_q;
  assign bus.initializing = init_q;
  assign bus.init_addr    = addr_q;
  assign bus.init_data    = data_q;
  assign bus.ram_we_n     = we_n_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;

endmodule
